timer_alarm: RTL and testbench

Four-channel millisecond alarm scheduler for the SoC timer subsystem. It keeps its own millisecond time base from the system clock. It lets software arm independent one-shot or periodic countdown channels, and it raises a single level interrupt when any enabled channel expires. It sits on the CPU peripheral bus next to the free-running millisecond timer, using the same single-cycle strobe/acknowledge bus style.

---
 rtl/timer_alarm_if.sv | 26 ++
 rtl/timer_alarm.sv | 184 ++++++++++++++++++
 tb/tb_timer_alarm.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_alarm_if.sv
// timer_alarm_if: single-cycle strobe/acknowledge peripheral bus.
//   i_addr  : byte address of the register
//   i_stb   : access strobe, one cycle per access
//   i_we    : write enable, qualified by i_stb
//   i_dat_w : write data
//   o_dat_r : read data, combinational from i_addr
//   o_ack   : zero-wait-state acknowledge (follows i_stb)
`timescale 1ns/1ps
interface timer_alarm_if;
  logic [5:0]  i_addr;
  logic        i_stb;
  logic        i_we;
  logic [31:0] i_dat_w;
  logic [31:0] o_dat_r;
  logic        o_ack;

  modport master (
    output i_addr, i_stb, i_we, i_dat_w,
    input  o_dat_r, o_ack
  );

  modport slave (
    input  i_addr, i_stb, i_we, i_dat_w,
    output o_dat_r, o_ack
  );
endinterface

// File: rtl/timer_alarm.sv
// timer_alarm: four-channel millisecond alarm scheduler.
// Derives a millisecond tick from the system clock, keeps a free-running
// millisecond count (NOW) and runs four one-shot/periodic countdown channels
// that set pending bits on expiry; o_irq is the registered OR of the enabled
// pending bits.
//   i_clk : system clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : register bus (slave side)
//   o_irq : level-high interrupt, registered
`timescale 1ns/1ps
module timer_alarm #(
  parameter int unsigned FREQ_HZ = 25_000_000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  timer_alarm_if.slave bus,
  output logic         o_irq
);

  localparam int unsigned PRESC  = FREQ_HZ / 1000;
  localparam int unsigned PCNT_W = $clog2(PRESC);
  localparam int unsigned NCH    = 4;
  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 6;

  localparam logic [AW-1:0] A_STATUS = 6'h00;
  localparam logic [AW-1:0] A_IRQEN  = 6'h04;
  localparam logic [AW-1:0] A_NOW    = 6'h08;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_ARMED = 1'b1
  } ch_state_e;

  // COUNT[n] sits at 0x10 + 8n, CTRL[n] four bytes above it
  function automatic logic [AW-1:0] count_addr(input int n);
    return AW'(16 + 8 * n);
  endfunction

  function automatic logic [AW-1:0] ctrl_addr(input int n);
    return AW'(20 + 8 * n);
  endfunction

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0]     now_q, now_d;
  ch_state_e         state_q  [NCH];
  ch_state_e         state_d  [NCH];
  logic [DW-1:0]     remain_q [NCH];
  logic [DW-1:0]     remain_d [NCH];
  logic [DW-1:0]     reload_q [NCH];
  logic [DW-1:0]     reload_d [NCH];
  logic [NCH-1:0]    periodic_q, periodic_d;
  logic [NCH-1:0]    pending_q, pending_d;
  logic [NCH-1:0]    irqen_q, irqen_d;
  logic              irq_q, irq_d;

  logic              ms_tick_c;
  logic              wr_c;
  logic [NCH-1:0]    set_c;
  logic [NCH-1:0]    w1c_c;
  logic [DW-1:0]     rdata_c;

  assign ms_tick_c = (pcnt_q == PCNT_W'(PRESC - 1));
  assign wr_c      = bus.i_stb & bus.i_we;

  // State registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pcnt_q     <= '0;
      now_q      <= '0;
      periodic_q <= '0;
      pending_q  <= '0;
      irqen_q    <= '0;
      irq_q      <= 1'b0;
      for (int n = 0; n < NCH; n++) begin
        state_q[n]  <= CH_IDLE;
        remain_q[n] <= '0;
        reload_q[n] <= '0;
      end
    end else begin
      pcnt_q     <= pcnt_d;
      now_q      <= now_d;
      periodic_q <= periodic_d;
      pending_q  <= pending_d;
      irqen_q    <= irqen_d;
      irq_q      <= irq_d;
      for (int n = 0; n < NCH; n++) begin
        state_q[n]  <= state_d[n];
        remain_q[n] <= remain_d[n];
        reload_q[n] <= reload_d[n];
      end
    end
  end

  // Next state: prescaler, time base, channel FSMs, register writes
  always_comb begin
    pcnt_d     = ms_tick_c ? '0 : pcnt_q + PCNT_W'(1);
    now_d      = ms_tick_c ? now_q + DW'(1) : now_q;
    periodic_d = periodic_q;
    irqen_d    = irqen_q;
    set_c      = '0;
    w1c_c      = '0;
    for (int n = 0; n < NCH; n++) begin
      state_d[n]  = state_q[n];
      remain_d[n] = remain_q[n];
      reload_d[n] = reload_q[n];
    end

    for (int n = 0; n < NCH; n++) begin
      // Tick evaluation; expiry uses the PERIODIC value held before any write
      if (ms_tick_c && state_q[n] == CH_ARMED) begin
        if (remain_q[n] > DW'(1)) begin
          remain_d[n] = remain_q[n] - DW'(1);
        end else begin
          set_c[n] = 1'b1;
          if (periodic_q[n]) begin
            remain_d[n] = reload_q[n];
          end else begin
            remain_d[n] = '0;
            state_d[n]  = CH_IDLE;
          end
        end
      end

      // A write in the same cycle overrides the tick, including its expiry
      if (wr_c && bus.i_addr == count_addr(n)) begin
        set_c[n] = 1'b0;
        if (bus.i_dat_w != '0) begin
          reload_d[n] = bus.i_dat_w;
          remain_d[n] = bus.i_dat_w;
          state_d[n]  = CH_ARMED;
        end else begin
          remain_d[n] = '0;
          state_d[n]  = CH_IDLE;
        end
      end

      if (wr_c && bus.i_addr == ctrl_addr(n)) begin
        periodic_d[n] = bus.i_dat_w[0];
        if (bus.i_dat_w[2]) begin
          set_c[n]    = 1'b0;
          remain_d[n] = '0;
          state_d[n]  = CH_IDLE;
        end
      end
    end

    if (wr_c && bus.i_addr == A_STATUS) begin
      w1c_c = bus.i_dat_w[NCH-1:0];
    end
    if (wr_c && bus.i_addr == A_IRQEN) begin
      irqen_d = bus.i_dat_w[NCH-1:0];
    end

    // A same-cycle expiry beats the W1C of its own bit
    pending_d = (pending_q & ~w1c_c) | set_c;
    irq_d     = |(pending_q & irqen_q);
  end

  // Read mux, combinational from the address
  always_comb begin
    rdata_c = '0;
    case (bus.i_addr)
      A_STATUS: rdata_c = DW'(pending_q);
      A_IRQEN:  rdata_c = DW'(irqen_q);
      A_NOW:    rdata_c = now_q;
      default: begin
        for (int n = 0; n < NCH; n++) begin
          if (bus.i_addr == count_addr(n)) begin
            rdata_c = remain_q[n];
          end
          if (bus.i_addr == ctrl_addr(n)) begin
            rdata_c = {30'd0, state_q[n] == CH_ARMED, periodic_q[n]};
          end
        end
      end
    endcase
  end

  assign bus.o_dat_r = rdata_c;
  assign bus.o_ack   = bus.i_stb;
  assign o_irq       = irq_q;

endmodule

// File: tb/tb_timer_alarm.sv
// tb_timer_alarm: self-checking bench for timer_alarm.
// The reference model tracks each channel as an absolute deadline in
// millisecond ticks rather than a countdown; remain is derived as
// deadline - now when a COUNT register is read.
`timescale 1ns/1ps
module tb_timer_alarm;

  localparam int unsigned FREQ_HZ = 10_000;
  localparam int unsigned PRESC   = FREQ_HZ / 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  timer_alarm_if bus ();

  timer_alarm #(.FREQ_HZ(FREQ_HZ)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus),
    .o_irq (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned     edges;
  logic [3:0]      m_pend;
  logic [3:0]      m_irqen;
  logic            m_irq;
  logic            m_armed    [4];
  logic            m_per      [4];
  logic [31:0]     m_reload   [4];
  longint unsigned m_deadline [4];

  logic [5:0] regs [14] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18,
                            6'h1C, 6'h20, 6'h24, 6'h28, 6'h2C, 6'h30, 6'h3C};

  function automatic longint unsigned m_now();
    return longint'(edges / PRESC);
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 6'h00) r = {28'd0, m_pend};
    if (a == 6'h04) r = {28'd0, m_irqen};
    if (a == 6'h08) r = 32'(m_now());
    for (int n = 0; n < 4; n++) begin
      if (a == 6'(16 + 8 * n)) r = m_armed[n] ? 32'(m_deadline[n] - m_now()) : 32'd0;
      if (a == 6'(20 + 8 * n)) r = {30'd0, m_armed[n], m_per[n]};
    end
    return r;
  endfunction

  task automatic model_reset();
    edges   = 0;
    m_pend  = '0;
    m_irqen = '0;
    m_irq   = 1'b0;
    for (int n = 0; n < 4; n++) begin
      m_armed[n]    = 1'b0;
      m_per[n]      = 1'b0;
      m_reload[n]   = '0;
      m_deadline[n] = 0;
    end
  endtask

  // Apply one rising edge to the model, given what the bus drove that cycle
  task automatic model_edge(input logic s, input logic w, input logic [5:0] a,
                            input logic [31:0] d);
    logic [3:0]      set_b;
    logic [3:0]      w1c;
    logic            irq_next;
    longint unsigned nowm;
    irq_next = |(m_pend & m_irqen);
    edges++;
    nowm  = m_now();
    set_b = '0;
    w1c   = '0;
    if (edges % PRESC == 0) begin
      for (int n = 0; n < 4; n++) begin
        if (m_armed[n] && m_deadline[n] == nowm) begin
          set_b[n] = 1'b1;
          if (m_per[n]) m_deadline[n] = m_deadline[n] + 64'(m_reload[n]);
          else          m_armed[n] = 1'b0;
        end
      end
    end
    if (s && w) begin
      if (a == 6'h00) w1c = d[3:0];
      if (a == 6'h04) m_irqen = d[3:0];
      for (int n = 0; n < 4; n++) begin
        if (a == 6'(16 + 8 * n)) begin
          set_b[n] = 1'b0;
          if (d != 0) begin
            m_armed[n]    = 1'b1;
            m_reload[n]   = d;
            m_deadline[n] = nowm + 64'(d);
          end else begin
            m_armed[n] = 1'b0;
          end
        end
        if (a == 6'(20 + 8 * n)) begin
          m_per[n] = d[0];
          if (d[2]) begin
            m_armed[n] = 1'b0;
            set_b[n]   = 1'b0;
          end
        end
      end
    end
    m_pend = (m_pend & ~w1c) | set_b;
    m_irq  = irq_next;
  endtask

  // One clock cycle of bus activity; entered and left just after a falling edge
  task automatic cycle(input logic s, input logic w, input logic [5:0] a,
                       input logic [31:0] d);
    bus.i_stb   = s;
    bus.i_we    = w;
    bus.i_addr  = a;
    bus.i_dat_w = d;
    @(posedge clk);
    model_edge(s, w, a, d);
    @(negedge clk);
    bus.i_stb = 1'b0;
    bus.i_we  = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 6'h00, 32'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  // Zero-edge read: strobe, settle, sample, release
  task automatic rd(input logic [5:0] a, output logic [31:0] v);
    bus.i_stb  = 1'b1;
    bus.i_we   = 1'b0;
    bus.i_addr = a;
    #0.1;
    v = bus.o_dat_r;
    bus.i_stb = 1'b0;
  endtask

  task automatic do_reset();
    bus.i_stb = 1'b0;
    bus.i_we  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      rd(regs[i], v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg addr=%h got=%h exp=0", regs[i], v);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    bus.i_stb = 1'b1;
    #0.1;
    checks++;
    if (bus.o_ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_high got=%b exp=1", bus.o_ack);
    end
    bus.i_stb = 1'b0;
    #0.1;
    checks++;
    if (bus.o_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_low got=%b exp=0", bus.o_ack);
    end
    idle(30);
    rd(6'h08, v);
    checks++;
    if (v !== 32'd3) begin
      errors++;
      $display("FAIL now_30 got=%0d exp=3", v);
    end
    // NOW must step exactly every PRESC edges
    for (int k = 0; k < 25; k++) begin
      idle(1);
      rd(6'h08, v);
      checks++;
      if (v !== 32'(edges / PRESC)) begin
        errors++;
        $display("FAIL tick_period edge=%0d got=%0d exp=%0d", edges, v, edges / PRESC);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    int unsigned a;
    bit got;
    do_reset();
    wr(6'h04, 32'h1);
    wr(6'h10, 32'd5);
    a   = edges / PRESC;
    got = 1'b0;
    for (int k = 0; k < 10 * PRESC && !got; k++) begin
      idle(1);
      rd(6'h00, v);
      if (v[0]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL oneshot_timeout got=0 exp=1");
    end
    checks++;
    if (edges !== (a + 5) * PRESC) begin
      errors++;
      $display("FAIL oneshot_edge got=%0d exp=%0d", edges, (a + 5) * PRESC);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_irq_early got=%b exp=0", irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_irq_rise got=%b exp=1", irq);
    end
    rd(6'h14, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL oneshot_ctrl got=%h exp=0", v);
    end
    rd(6'h10, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL oneshot_count got=%h exp=0", v);
    end
    wr(6'h00, 32'h1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_irq_hold got=%b exp=1", irq);
    end
    idle(1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_irq_fall got=%b exp=0", irq);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    int unsigned a;
    int t;
    do_reset();
    wr(6'h1C, 32'h1);
    wr(6'h18, 32'd3);
    a = edges / PRESC;
    wr(6'h04, 32'h2);
    while (edges < (a + 11) * PRESC) begin
      idle(1);
      if (edges % PRESC == 0) begin
        t = int'(edges / PRESC) - int'(a);
        rd(6'h00, v);
        checks++;
        if (v[1] !== (t == 3 || t == 6)) begin
          errors++;
          $display("FAIL periodic_pend tick=%0d got=%b exp=%b", t, v[1], (t == 3 || t == 6));
        end
        if (v[1]) begin
          wr(6'h00, 32'h2);
          checks++;
          if (irq !== 1'b1) begin
            errors++;
            $display("FAIL periodic_irq tick=%0d got=%b exp=1", t, irq);
          end
        end
        if (t == 7) wr(6'h1C, 32'h5);
      end
    end
    rd(6'h1C, v);
    checks++;
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL periodic_ctrl got=%h exp=1", v);
    end
    rd(6'h18, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL periodic_count got=%h exp=0", v);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    int unsigned n, a, e;
    do_reset();
    n = $urandom_range(2, 6);
    while (edges % PRESC != 1) idle(1);
    wr(6'h10, n);
    wr(6'h20, n);
    a = edges / PRESC;
    e = (a + n) * PRESC;
    while (edges < e - 1) idle(1);
    wr(6'h00, 32'h1);
    rd(6'h00, v);
    checks++;
    if (v !== 32'h5) begin
      errors++;
      $display("FAIL simul_status n=%0d got=%h exp=5", n, v);
    end
    checks++;
    if (v !== model_read(6'h00)) begin
      errors++;
      $display("FAIL simul_model got=%h exp=%h", v, model_read(6'h00));
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    int unsigned a, e;
    do_reset();
    while ((edges + 1) % PRESC != 0) idle(1);
    wr(6'h28, 32'd2);
    rd(6'h28, v);
    checks++;
    if (v !== 32'd2) begin
      errors++;
      $display("FAIL coll_remain got=%0d exp=2", v);
    end
    a = edges / PRESC;
    e = (a + 2) * PRESC;
    while (edges < e) begin
      idle(1);
      if (edges % PRESC == 0) begin
        rd(6'h00, v);
        checks++;
        if (v[3] !== (edges == e)) begin
          errors++;
          $display("FAIL coll_expiry edge=%0d got=%b exp=%b", edges, v[3], (edges == e));
        end
      end
    end
    wr(6'h00, 32'h8);
    wr(6'h28, 32'd2);
    a = edges / PRESC;
    e = (a + 2) * PRESC;
    while (edges < e - 1) idle(1);
    wr(6'h28, 32'd0);
    rd(6'h00, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL coll_disarm_pend got=%h exp=0", v);
    end
    rd(6'h2C, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL coll_disarm_ctrl got=%h exp=0", v);
    end
  endtask

  task automatic test_random();
    logic [31:0] v, d;
    logic [5:0]  a;
    int unsigned op;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      op = $urandom_range(0, 9);
      a  = regs[$urandom_range(0, 13)];
      if (a >= 6'h10 && a < 6'h30) d = 32'($urandom_range(0, 7));
      else                         d = $urandom;
      if (op < 4)       idle(1);
      else if (op == 4) cycle(1'b1, 1'b0, a, d);
      else              wr(a, d);
      checks++;
      if (irq !== m_irq) begin
        errors++;
        $display("FAIL rand_irq cyc=%0d got=%b exp=%b", k, irq, m_irq);
      end
      for (int i = 0; i < 14; i++) begin
        rd(regs[i], v);
        checks++;
        if (v !== model_read(regs[i])) begin
          errors++;
          $display("FAIL rand_reg cyc=%0d addr=%h got=%h exp=%h", k, regs[i], v, model_read(regs[i]));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    do_reset();
    wr(6'h04, 32'h1);
    wr(6'h1C, 32'h1);
    wr(6'h18, 32'd100);
    wr(6'h10, 32'd1);
    for (int k = 0; k < 2 * PRESC && m_pend[0] !== 1'b1; k++) idle(1);
    idle(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_irq got=%b exp=1", irq);
    end
    #1;
    rst = 1'b1;
    #0.1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL areset_irq got=%b exp=0", irq);
    end
    for (int i = 0; i < 14; i++) begin
      rd(regs[i], v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL areset_reg addr=%h got=%h exp=0", regs[i], v);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.i_stb   = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_addr  = 6'h00;
    bus.i_dat_w = 32'd0;
    model_reset();
    test_reset();
    test_oneshot();
    test_periodic();
    test_simultaneous();
    test_collision();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
